// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: operand/tag/opcode widths, opcode encoding and the
// reservation-station entry layout.
package tomasulo_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_LD  = 4'd4,
    OP_ST  = 4'd5
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob_tag;
    logic              qj_valid;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic              qk_valid;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } rs_entry_t;

  // True when a pending operand waiting on tag q is satisfied by this cycle's CDB.
  function automatic logic tag_hit(input logic pending, input logic [TAG_W-1:0] q,
                                   input logic cdb_v, input logic [TAG_W-1:0] cdb_t);
    return pending && cdb_v && (q == cdb_t);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station. r_older[i][j]=1 means entry j was
// issued before entry i. Grants the oldest entry among those marked ready.
module rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [DEPTH-1:0] i_insert_oh,
  input  logic [DEPTH-1:0] i_remove_oh,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_older [DEPTH];

  // Row i is rebuilt on insert from the survivors; removed/inserted columns drop out of every row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_insert_oh[i])
          r_older[i] <= i_valid & ~i_remove_oh;
        else if (i_remove_oh[i])
          r_older[i] <= '0;
        else
          r_older[i] <= r_older[i] & ~i_insert_oh & ~i_remove_oh;
      end
    end
  end

  // An entry wins if it is ready and no ready entry is older than it.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_ready[i] & ~(|(r_older[i] & i_ready));
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: captures operands from issue or the CDB and
// dispatches the oldest ready entry to one functional unit.
// Optional macro RS_FLUSH_EN adds a synchronous i_flush port that empties the station.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef RS_FLUSH_EN
  input  logic                       i_flush,
`endif
  input  logic                       i_issue_valid,
  output logic                       o_issue_ready,
  input  logic [OP_W-1:0]            i_issue_op,
  input  logic [TAG_W-1:0]           i_issue_rob_tag,
  input  logic                       i_issue_qj_valid,
  input  logic [TAG_W-1:0]           i_issue_qj,
  input  logic [DATA_W-1:0]          i_issue_vj,
  input  logic                       i_issue_qk_valid,
  input  logic [TAG_W-1:0]           i_issue_qk,
  input  logic [DATA_W-1:0]          i_issue_vk,
  input  logic                       i_cdb_valid,
  input  logic [TAG_W-1:0]           i_cdb_tag,
  input  logic [DATA_W-1:0]          i_cdb_data,
  output logic                       o_ex_valid,
  input  logic                       i_ex_ready,
  output logic [OP_W-1:0]            o_ex_op,
  output logic [TAG_W-1:0]           o_ex_rob_tag,
  output logic [DATA_W-1:0]          o_ex_vj,
  output logic [DATA_W-1:0]          o_ex_vk,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  rs_entry_t        r_ent [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic             w_flush;
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_ins_oh;
  logic [DEPTH-1:0] w_rem_oh;
  logic             w_free_hit;
  logic             w_issue_fire;
  logic             w_disp_fire;
  logic             w_byp_j;
  logic             w_byp_k;
  rs_entry_t        w_new;

`ifdef RS_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign o_issue_ready = (r_occ != OCC_W'(DEPTH));
  assign o_occupancy   = r_occ;
  assign w_issue_fire  = i_issue_valid & o_issue_ready & ~w_flush;
  assign o_ex_valid    = (|w_ready) & ~w_flush;
  assign w_disp_fire   = o_ex_valid & i_ex_ready;
  assign w_rem_oh      = w_grant & {DEPTH{w_disp_fire}};

  // Per-entry valid and operand-ready vectors from registered state only.
  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_ready[i] = r_ent[i].valid & ~r_ent[i].qj_valid & ~r_ent[i].qk_valid;
    end
  end

  // Lowest-index free slot receives the issuing instruction.
  always_comb begin
    w_ins_oh   = '0;
    w_free_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_ent[i].valid && !w_free_hit) begin
        w_ins_oh[i] = w_issue_fire;
        w_free_hit  = 1'b1;
      end
    end
  end

  // New entry image, with operands resolved by a same-cycle CDB broadcast.
  always_comb begin
    w_byp_j          = tag_hit(i_issue_qj_valid, i_issue_qj, i_cdb_valid, i_cdb_tag);
    w_byp_k          = tag_hit(i_issue_qk_valid, i_issue_qk, i_cdb_valid, i_cdb_tag);
    w_new.valid      = 1'b1;
    w_new.op         = i_issue_op;
    w_new.rob_tag    = i_issue_rob_tag;
    w_new.qj_valid   = i_issue_qj_valid & ~w_byp_j;
    w_new.qj         = i_issue_qj;
    w_new.vj         = w_byp_j ? i_cdb_data : i_issue_vj;
    w_new.qk_valid   = i_issue_qk_valid & ~w_byp_k;
    w_new.qk         = i_issue_qk;
    w_new.vk         = w_byp_k ? i_cdb_data : i_issue_vk;
  end

  // Entry storage: dispatch frees, CDB wakes pending operands, issue writes a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_occ <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rem_oh[i]) r_ent[i].valid <= 1'b0;
        if (tag_hit(r_ent[i].qj_valid, r_ent[i].qj, i_cdb_valid, i_cdb_tag)) begin
          r_ent[i].vj       <= i_cdb_data;
          r_ent[i].qj_valid <= 1'b0;
        end
        if (tag_hit(r_ent[i].qk_valid, r_ent[i].qk, i_cdb_valid, i_cdb_tag)) begin
          r_ent[i].vk       <= i_cdb_data;
          r_ent[i].qk_valid <= 1'b0;
        end
        if (w_ins_oh[i]) r_ent[i] <= w_new;
      end
      r_occ <= r_occ + OCC_W'(w_issue_fire) - OCC_W'(w_disp_fire);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_flush),
    .i_insert_oh (w_ins_oh),
    .i_remove_oh (w_rem_oh),
    .i_valid     (w_valid),
    .i_ready     (w_ready),
    .o_grant     (w_grant)
  );

  // Present the granted entry to the functional unit.
  always_comb begin
    o_ex_op      = '0;
    o_ex_rob_tag = '0;
    o_ex_vj      = '0;
    o_ex_vk      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        o_ex_op      = r_ent[i].op;
        o_ex_rob_tag = r_ent[i].rob_tag;
        o_ex_vj      = r_ent[i].vj;
        o_ex_vk      = r_ent[i].vk;
      end
    end
  end

endmodule
